sram_port_arbiter: RTL

// - Shares one single-port synchronous SRAM between the CPU fetch requester (inst, read-only) and the load/store requester (data, read/write).
// - Sits between the multi-cycle core's IF/MEM stages and a unified inst/data SRAM.
// - One access is granted per cycle. Data has priority over inst. A starvation guard guarantees inst progress.

---
 rtl/sram_port_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter sharing one single-port synchronous SRAM between fetch (inst) and load/store (data).
// Optional grant performance counters are enabled with `define ARB_PERF_CNT_EN.
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       perf_inst_cnt,
  output logic [31:0]       perf_data_cnt,
`endif
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       starve_hit;
  logic       sel_inst;
  logic       rsp_inst;
  logic       rsp_data;

  assign starve_hit = (starve_cnt == LIMIT);

  // Grants are gated by resetn so nothing reaches the SRAM while in reset.
  always_comb begin
    sel_inst   = resetn & inst_req & (~data_req | starve_hit);
    inst_gnt   = sel_inst;
    data_gnt   = resetn & data_req & ~sel_inst;
    sram_en    = inst_gnt | data_gnt;
    sram_we    = data_gnt & data_we;
    sram_addr  = '0;
    sram_wdata = '0;
    if (data_gnt) begin
      sram_addr = data_addr;
    end else if (inst_gnt) begin
      sram_addr = inst_addr;
    end
    if (sram_we) begin
      sram_wdata = data_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (inst_gnt) begin
      starve_cnt <= '0;
    end else if (data_gnt && inst_req && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rsp_inst <= 1'b0;
      rsp_data <= 1'b0;
    end else begin
      rsp_inst <= inst_gnt;
      rsp_data <= data_gnt & ~data_we;
    end
  end

  assign inst_rvalid = rsp_inst;
  assign data_rvalid = rsp_data;
  assign inst_rdata  = sram_rdata;
  assign data_rdata  = sram_rdata;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_inst_cnt <= '0;
      perf_data_cnt <= '0;
    end else begin
      if (inst_gnt && (perf_inst_cnt != '1)) begin
        perf_inst_cnt <= perf_inst_cnt + 32'd1;
      end
      if (data_gnt && (perf_data_cnt != '1)) begin
        perf_data_cnt <= perf_data_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
